// File: rtl/data_sram_like_slave.sv
// Bridge from an SRAM-like request/handshake master port to a synchronous single-port SRAM.
// One transaction in flight; ADDR_DELAY/DATA_DELAY stretch the address and data handshakes.
module data_sram_like_slave #(
    parameter int unsigned ADDR_DELAY = 0,
    parameter int unsigned DATA_DELAY = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    // state   | meaning
    // IDLE    | waiting for data_req; acc_cnt counts cycles the request has been held
    // ACCESS  | one-cycle SRAM access using the latched request fields
    // CAPTURE | SRAM read data valid; captured into rdata_q
    // WAIT    | DATA_DELAY extra cycles, wait_cnt counts down to zero
    // RESP    | one-cycle data_data_ok pulse
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCESS  = 3'd1,
        S_CAPTURE = 3'd2,
        S_WAIT    = 3'd3,
        S_RESP    = 3'd4
    } state_e;

    localparam logic [3:0] ADDR_DLY  = 4'(ADDR_DELAY);
    localparam logic [3:0] WAIT_LOAD = (DATA_DELAY > 0) ? 4'(DATA_DELAY - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  acc_cnt_q, acc_cnt_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        wr_q;
    logic [29:0] waddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic [3:0]  be_req;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            acc_cnt_q  <= 4'd0;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // acc_cnt is held at zero outside IDLE so a request held through a transaction
    // starts its address delay afresh once the block is idle again.
    always_comb begin
        state_d    = state_q;
        acc_cnt_d  = 4'd0;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (data_addr_ok) begin
                    state_d = S_ACCESS;
                end else if (data_req) begin
                    acc_cnt_d = acc_cnt_q + 4'd1;
                end
            end
            S_ACCESS: state_d = S_CAPTURE;
            S_CAPTURE: begin
                wait_cnt_d = WAIT_LOAD;
                state_d    = (DATA_DELAY > 0) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // addr_ok is gated by resetn so a request held during reset is never acknowledged.
    always_comb begin
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        sram_en      = 1'b0;
        sram_wen     = 4'b0000;
        unique case (state_q)
            S_IDLE:   data_addr_ok = resetn & data_req & (acc_cnt_q == ADDR_DLY);
            S_ACCESS: begin
                sram_en  = 1'b1;
                sram_wen = wr_q ? be_q : 4'b0000;
            end
            S_RESP:   data_data_ok = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        be_req = 4'b1111;
        unique case (data_size)
            2'b00:   be_req = 4'b0001 << data_addr[1:0];
            2'b01:   be_req = data_addr[1] ? 4'b1100 : 4'b0011;
            default: be_req = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q    <= 1'b0;
            waddr_q <= 30'd0;
            wdata_q <= 32'h0;
            be_q    <= 4'b0000;
            rdata_q <= 32'h0;
        end else begin
            if (data_addr_ok) begin
                wr_q    <= data_wr;
                waddr_q <= data_addr[31:2];
                wdata_q <= data_wdata;
                be_q    <= be_req;
            end
            if (state_q == S_CAPTURE) begin
                rdata_q <= wr_q ? 32'h0 : sram_rdata;
            end
        end
    end

    assign sram_addr  = {waddr_q, 2'b00};
    assign sram_wdata = wdata_q;
    assign data_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_like_slave.sv
// Scoreboard bench for data_sram_like_slave: instance 0 uses default delays,
// instance 1 uses ADDR_DELAY=2 / DATA_DELAY=3; each has its own SRAM model.
module tb_data_sram_like_slave;

    localparam int NI  = 2;
    localparam int AD1 = 2;
    localparam int DD1 = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  wen;
        logic [31:0] saddr;
        logic [31:0] wdata;
        int          acc_cyc;
        int          ok_cyc;
    } exp_t;

    logic clk;
    logic resetn;
    logic [NI-1:0]       req, wr, addr_ok, data_ok, sram_en;
    logic [NI-1:0][1:0]  size;
    logic [NI-1:0][31:0] addr, wdata, rdata, sram_addr, sram_wdata, sram_rdata;
    logic [NI-1:0][3:0]  sram_wen;

    logic [31:0] mem     [NI][256];
    logic [31:0] ref_mem [NI][256];
    exp_t        sbq     [NI][$];

    int cyc = 0;
    int errs = 0;
    int checks = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_sram_like_slave #(
            .ADDR_DELAY(g == 0 ? 0 : AD1),
            .DATA_DELAY(g == 0 ? 0 : DD1)
        ) u_dut (
            .clk          (clk),
            .resetn       (resetn),
            .data_req     (req[g]),
            .data_wr      (wr[g]),
            .data_size    (size[g]),
            .data_addr    (addr[g]),
            .data_wdata   (wdata[g]),
            .data_rdata   (rdata[g]),
            .data_addr_ok (addr_ok[g]),
            .data_data_ok (data_ok[g]),
            .sram_en      (sram_en[g]),
            .sram_wen     (sram_wen[g]),
            .sram_addr    (sram_addr[g]),
            .sram_wdata   (sram_wdata[g]),
            .sram_rdata   (sram_rdata[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ad_of(input int k);
        return (k == 0) ? 0 : AD1;
    endfunction

    function automatic int dd_of(input int k);
        return (k == 0) ? 0 : DD1;
    endfunction

    function automatic logic [31:0] init_word(input int k, input int i);
        if (i == 'h40) return 32'hDEADBEEF;
        return 32'h1357_0000 ^ (32'(i) * 32'h0001_0003) ^ (32'(k) << 28);
    endfunction

    function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Synchronous SRAM model: read data appears the cycle after sram_en.
    initial begin
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 256; i++) mem[k][i] = init_word(k, i);
        sram_rdata = '0;
        forever begin
            @(posedge clk);
            for (int k = 0; k < NI; k++) begin
                if (sram_en[k]) begin
                    sram_rdata[k] <= mem[k][sram_addr[k][9:2]];
                    for (int b = 0; b < 4; b++)
                        if (sram_wen[k][b]) mem[k][sram_addr[k][9:2]][8*b +: 8] = sram_wdata[k][8*b +: 8];
                end
            end
        end
    end

    // Scoreboard: the front entry dictates the exact cycle of sram_en and data_data_ok.
    always @(negedge clk) begin
        if (resetn) begin
            for (int k = 0; k < NI; k++) begin
                logic exp_en;
                logic exp_ok;
                exp_t e;
                exp_en = 1'b0;
                exp_ok = 1'b0;
                e      = '0;
                if (sbq[k].size() != 0) begin
                    e      = sbq[k][0];
                    exp_en = (cyc == e.acc_cyc);
                    exp_ok = (cyc == e.ok_cyc);
                end
                check_eq($sformatf("sram_en[%0d]", k), 32'(sram_en[k]), 32'(exp_en));
                check_eq($sformatf("sram_wen[%0d]", k), 32'(sram_wen[k]), exp_en ? 32'(e.wen) : 32'h0);
                if (exp_en) begin
                    check_eq($sformatf("sram_addr[%0d]", k), sram_addr[k], e.saddr);
                    check_eq($sformatf("sram_wdata[%0d]", k), sram_wdata[k], e.wdata);
                end
                check_eq($sformatf("data_ok[%0d]", k), 32'(data_ok[k]), 32'(exp_ok));
                if (exp_ok) begin
                    check_eq($sformatf("rdata[%0d]", k), rdata[k], e.rdata);
                    void'(sbq[k].pop_front());
                end
            end
        end
    end

    task automatic wait_drain(input int k);
        int n;
        n = 0;
        while (sbq[k].size() != 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("drain[%0d]", k), 32'(sbq[k].size()), 32'h0);
    endtask

    // exp_hs < 0: block is idle, handshake expected ADDR_DELAY cycles after req rises.
    task automatic xfer(input int k, input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input bit keep, input int exp_hs, output int t_hs);
        int   t_rise;
        int   n;
        exp_t e;
        if (exp_hs < 0) wait_drain(k);
        @(negedge clk);
        req[k]   = 1'b1;
        wr[k]    = w;
        size[k]  = sz;
        addr[k]  = a;
        wdata[k] = wd;
        t_rise   = cyc;
        #1;
        n = 0;
        while (!addr_ok[k] && n < 64) begin
            @(negedge clk);
            #1;
            n++;
        end
        t_hs = cyc;
        check_eq($sformatf("hs_cycle[%0d]", k), 32'(t_hs), 32'((exp_hs < 0) ? t_rise + ad_of(k) : exp_hs));
        if (!addr_ok[k]) begin
            req[k] = 1'b0;
            return;
        end
        e.wen     = w ? be_of(sz, a[1:0]) : 4'b0000;
        e.saddr   = {a[31:2], 2'b00};
        e.wdata   = wd;
        e.rdata   = w ? 32'h0 : ref_mem[k][a[9:2]];
        e.acc_cyc = t_hs + 1;
        e.ok_cyc  = t_hs + 3 + dd_of(k);
        if (w)
            for (int b = 0; b < 4; b++)
                if (e.wen[b]) ref_mem[k][a[9:2]][8*b +: 8] = wd[8*b +: 8];
        sbq[k].push_back(e);
        if (!keep) begin
            @(negedge clk);
            req[k] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          t;
        int          t2;
        logic [31:0] exp_rd;

        resetn = 1'b0;
        req    = '0;
        wr     = '0;
        size   = '0;
        addr   = '0;
        wdata  = '0;
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 256; i++) ref_mem[k][i] = init_word(k, i);

        repeat (3) @(negedge clk);
        req[0] = 1'b1;
        #1;
        check_eq("aok_in_reset", 32'(addr_ok[0]), 32'h0);
        for (int k = 0; k < NI; k++) begin
            check_eq($sformatf("rst_en[%0d]", k), 32'(sram_en[k]), 32'h0);
            check_eq($sformatf("rst_wen[%0d]", k), 32'(sram_wen[k]), 32'h0);
            check_eq($sformatf("rst_ok[%0d]", k), 32'(data_ok[k]), 32'h0);
            check_eq($sformatf("rst_rdata[%0d]", k), rdata[k], 32'h0);
            check_eq($sformatf("rst_saddr[%0d]", k), sram_addr[k], 32'h0);
        end
        req[0] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Default-delay instance: directed reads/writes and lane enables.
        xfer(0, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, -1, t);
        xfer(0, 1'b1, 2'b00, 32'h203, 32'hAB00_0000, 1'b0, -1, t);
        xfer(0, 1'b0, 2'b10, 32'h200, 32'h0, 1'b0, -1, t);
        xfer(0, 1'b1, 2'b01, 32'h12, 32'h1234_0000, 1'b0, -1, t);
        xfer(0, 1'b1, 2'b01, 32'h13, 32'h5678_0000, 1'b0, -1, t);
        xfer(0, 1'b1, 2'b11, 32'h4, 32'hCAFE_F00D, 1'b0, -1, t);
        xfer(0, 1'b1, 2'b01, 32'h8, 32'h0000_BEEF, 1'b0, -1, t);
        xfer(0, 1'b1, 2'b00, 32'h9, 32'h0000_5A00, 1'b0, -1, t);
        xfer(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, -1, t);
        xfer(0, 1'b0, 2'b11, 32'h4, 32'h0, 1'b0, -1, t);
        xfer(0, 1'b0, 2'b00, 32'h9, 32'h0, 1'b0, -1, t);

        // Back-to-back with data_req held high; new fields driven while busy.
        xfer(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b1, -1, t);
        xfer(0, 1'b0, 2'b10, 32'h8, 32'h0, 1'b0, t + 4, t2);
        wait_drain(0);

        // Delayed instance: a one-cycle request pulse must not be accepted.
        @(negedge clk);
        req[1]  = 1'b1;
        wr[1]   = 1'b1;
        size[1] = 2'b10;
        addr[1] = 32'h20;
        #1;
        check_eq("pulse_aok", 32'(addr_ok[1]), 32'h0);
        @(negedge clk);
        req[1] = 1'b0;
        #1;
        check_eq("pulse_aok_after", 32'(addr_ok[1]), 32'h0);
        repeat (5) @(negedge clk);

        xfer(1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, -1, t);
        xfer(1, 1'b1, 2'b00, 32'h2, 32'h0077_0000, 1'b0, -1, t);
        xfer(1, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0, -1, t);
        xfer(1, 1'b0, 2'b10, 32'h30, 32'h0, 1'b1, -1, t);
        xfer(1, 1'b1, 2'b01, 32'h32, 32'hA5A5_0000, 1'b0, t + 4 + DD1 + AD1, t2);
        xfer(1, 1'b0, 2'b10, 32'h30, 32'h0, 1'b0, -1, t);

        // Reset asserted in the middle of WAIT aborts the read.
        xfer(1, 1'b0, 2'b10, 32'h44, 32'h0, 1'b0, -1, t);
        exp_rd = ref_mem[1][8'h11];
        while (cyc < t + 4) @(negedge clk);
        check_eq("rdata_hold_wait", rdata[1], exp_rd);
        sbq[1].delete();
        resetn = 1'b0;
        #1;
        check_eq("abort_ok", 32'(data_ok[1]), 32'h0);
        check_eq("abort_en", 32'(sram_en[1]), 32'h0);
        check_eq("abort_wen", 32'(sram_wen[1]), 32'h0);
        check_eq("abort_rdata", rdata[1], 32'h0);
        check_eq("abort_aok", 32'(addr_ok[1]), 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        xfer(1, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, -1, t);

        // Randomized traffic across both instances.
        for (int i = 0; i < 16; i++) begin
            logic        rw;
            logic [1:0]  rsz;
            logic [31:0] ra;
            logic [31:0] rwd;
            rw  = 1'($urandom_range(0, 1));
            rsz = 2'($urandom_range(0, 3));
            ra  = 32'($urandom_range(0, 1023));
            rwd = $urandom;
            xfer(i % 2, rw, rsz, ra, rwd, 1'b0, -1, t);
        end

        wait_drain(0);
        wait_drain(1);
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
